// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and constants for imem_loader
// Purpose: loader FSM state type and the default frame start marker.
// Ports: none (package).
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - 4-byte big-endian word assembler
// Purpose: shifts payload bytes into a 32-bit word and pulses word_valid for
//   one cycle after the 4th byte of each word.
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous, active-low reset
//   clear      in   1   restart byte indexing at the first byte of a word
//   in_valid   in   1   payload byte accepted this cycle
//   in_data    in   8   payload byte
//   word       out  32  assembled word (stable while word_valid is high)
//   word_valid out  1   one-cycle pulse, the cycle after the 4th byte
//   last_byte  out  1   the next accepted byte completes a word
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte
);

  logic [1:0] idx;

  assign last_byte = (idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx <= 2'd0;
      end else if (in_valid) begin
        // First byte ends up in the top lane: big-endian.
        word       <= {word[23:0], in_data};
        idx        <= idx + 2'd1;
        word_valid <= last_byte;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the CPU instruction memory
// Purpose: receives SYNC, CNT_HI, CNT_LO, N big-endian words, XOR checksum;
//   writes the words into imem and holds the core in reset while loading.
// Optional feature: LOADER_TIMEOUT_EN enables an inter-byte timeout that
//   rejects the frame after TIMEOUT_CYC idle cycles mid-frame.
// Ports:
//   clk       in   1       system clock, rising edge
//   rst       in   1       asynchronous, active-low reset
//   rx_valid  in   1       host byte valid
//   rx_data   in   8       host byte
//   rx_ready  out  1       byte accepted when rx_valid & rx_ready
//   im_we     out  1       imem write strobe, one pulse per word
//   im_addr   out  ADDR_W  imem word index
//   im_wdata  out  32      instruction word
//   cpu_rst   out  1       active-high hold-in-reset for the core
//   done      out  1       image loaded with a good checksum (level)
//   err       out  1       frame rejected (level)
module imem_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t      state;
  logic [7:0]  cnt_hi;
  logic [16:0] words_left;
  logic [7:0]  csum;
  logic        accept;
  logic        is_sync;
  logic        waiting_sync;
  logic        asm_last;
  logic [16:0] count_n;

  // Refusing a byte during the write cycle keeps the next word from
  // overlapping the imem write in progress.
  assign rx_ready     = ~im_we;
  assign accept       = rx_valid & rx_ready;
  assign is_sync      = (rx_data == SYNC_BYTE);
  assign waiting_sync = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign count_n      = {1'b0, cnt_hi, rx_data};

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept && waiting_sync && is_sync),
    .in_valid   (accept && (state == ST_DATA)),
    .in_data    (rx_data),
    .word       (im_wdata),
    .word_valid (im_we),
    .last_byte  (asm_last)
  );

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] idle_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt_hi     <= 8'd0;
      words_left <= 17'd0;
      csum       <= 8'd0;
      im_addr    <= '0;
      cpu_rst    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      idle_cnt   <= 32'd0;
`endif
    end else begin
      if (im_we) im_addr <= im_addr + 1'b1;

      if (accept) begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (is_sync) begin
              state   <= ST_CNT_HI;
              cpu_rst <= 1'b1;
              done    <= 1'b0;
              err     <= 1'b0;
              csum    <= 8'd0;
              im_addr <= '0;
            end
          end
          ST_CNT_HI: begin
            cnt_hi <= rx_data;
            csum   <= csum ^ rx_data;
            state  <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            csum       <= csum ^ rx_data;
            words_left <= count_n;
            if (count_n > MAX_WORDS) begin
              err   <= 1'b1;
              state <= ST_ERR;
            end else if (count_n == 17'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            csum <= csum ^ rx_data;
            if (asm_last) begin
              words_left <= words_left - 17'd1;
              if (words_left == 17'd1) state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (rx_data == csum) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
              state   <= ST_DONE;
            end else begin
              err   <= 1'b1;
              state <= ST_ERR;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

`ifdef LOADER_TIMEOUT_EN
      if (accept || waiting_sync) begin
        idle_cnt <= 32'd0;
      end else if (idle_cnt == 32'(TIMEOUT_CYC - 1)) begin
        idle_cnt <= 32'd0;
        err      <= 1'b1;
        cpu_rst  <= 1'b1;
        state    <= ST_ERR;
      end else begin
        idle_cnt <= idle_cnt + 32'd1;
      end
`endif
    end
  end

endmodule
